riscv_sc_core: RTL and testbench

//  Single-cycle RV32I-subset processor core: fetches one instruction per clock, executes it and retires it in that same clock.

---
 rtl/riscv_sc_pkg.sv | 48 ++++
 rtl/riscv_sc_regfile.sv | 36 +++
 rtl/riscv_sc_core.sv | 175 +++++++++++++++++
 tb/tb_riscv_sc_core.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_sc_pkg.sv
// riscv_sc_pkg: shared definitions for the single-cycle RV32I-subset core.
//   - opcode constants for the supported instruction classes
//   - ALU control, immediate-format and result-select encodings
//   - ext_imm(): sign-extends the I/S/B/J immediates from an instruction word
package riscv_sc_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  // B and J offsets come out with bit 0 forced to zero.
  function automatic logic [31:0] ext_imm(input logic [31:0] ins, input imm_src_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/riscv_sc_regfile.sv
// riscv_sc_regfile: 32x32 register file, two combinational read ports and one
// write port on the rising clock edge. x0 reads as zero and ignores writes.
// Ports:
//   clk       in  clock
//   rst       in  asynchronous active-low clear of x1..x31
//   we        in  write enable
//   ra1, ra2  in  read addresses
//   wa, wd    in  write address / data
//   rd1, rd2  out read data
module riscv_sc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  import riscv_sc_pkg::*;

  logic [31:0] regs [1:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/riscv_sc_core.sv
// riscv_sc_core: single-cycle RV32I-subset core (LW, SW, ADD/SUB/AND/OR/SLT,
// ADDI/ANDI/ORI/SLTI, BEQ, JAL). One instruction is fetched, executed and
// retired per clock. Unsupported encodings act as a NOP.
// Optional feature: define RISCV_SC_BNE_EN to decode BNE (branch funct3=001).
// Parameters:
//   n  data-memory byte address width
//   m  store data width (must be 32)
// Ports:
//   clk         in  clock, all state changes on rising edge
//   rst         in  asynchronous active-low reset (PC and GPRs cleared)
//   addr        out data-memory byte address (low n bits of ALU result)
//   write_data  out store data (rs2 value)
//   memwr       out data-memory write enable (SW only)
//   read_data   in  data-memory read data (combinational)
//   PC          out current program counter
//   instr       in  instruction at PC (combinational)
module riscv_sc_core #(
  parameter int n = 10,
  parameter int m = 32
) (
  input  logic         clk,
  input  logic         rst,
  output logic [n-1:0] addr,
  output logic [m-1:0] write_data,
  output logic         memwr,
  input  logic [31:0]  read_data,
  output logic [31:0]  PC,
  input  logic [31:0]  instr
);
  import riscv_sc_pkg::*;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic        regwrite;
  logic        mem_we;
  logic        alu_src;
  imm_src_e    imm_src;
  result_src_e result_src;
  alu_ctl_e    alu_ctl;
  logic        branch_eq;
  logic        branch_ne;
  logic        jump;

  // Main decoder: every field combination not listed falls through with all
  // write enables low, which makes it a NOP that advances to PC+4.
  always_comb begin
    regwrite   = 1'b0;
    mem_we     = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_I;
    result_src = RES_ALU;
    alu_ctl    = ALU_ADD;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    jump       = 1'b0;
    case (opcode)
      OP_LW: begin
        if (funct3 == 3'b010) begin
          regwrite   = 1'b1;
          alu_src    = 1'b1;
          result_src = RES_MEM;
        end
      end
      OP_SW: begin
        if (funct3 == 3'b010) begin
          mem_we  = 1'b1;
          alu_src = 1'b1;
          imm_src = IMM_S;
        end
      end
      OP_R: begin
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: begin regwrite = 1'b1; alu_ctl = ALU_ADD; end
          {7'b0100000, 3'b000}: begin regwrite = 1'b1; alu_ctl = ALU_SUB; end
          {7'b0000000, 3'b111}: begin regwrite = 1'b1; alu_ctl = ALU_AND; end
          {7'b0000000, 3'b110}: begin regwrite = 1'b1; alu_ctl = ALU_OR;  end
          {7'b0000000, 3'b010}: begin regwrite = 1'b1; alu_ctl = ALU_SLT; end
          default: ;
        endcase
      end
      OP_I: begin
        alu_src = 1'b1;
        case (funct3)
          3'b000: begin regwrite = 1'b1; alu_ctl = ALU_ADD; end
          3'b111: begin regwrite = 1'b1; alu_ctl = ALU_AND; end
          3'b110: begin regwrite = 1'b1; alu_ctl = ALU_OR;  end
          3'b010: begin regwrite = 1'b1; alu_ctl = ALU_SLT; end
          default: ;
        endcase
      end
      OP_BR: begin
        imm_src = IMM_B;
        alu_ctl = ALU_SUB;
        case (funct3)
          3'b000: branch_eq = 1'b1;
`ifdef RISCV_SC_BNE_EN
          3'b001: branch_ne = 1'b1;
`endif
          default: ;
        endcase
      end
      OP_JAL: begin
        regwrite   = 1'b1;
        jump       = 1'b1;
        imm_src    = IMM_J;
        result_src = RES_PC4;
      end
      default: ;
    endcase
  end

  logic [31:0] rd1, rd2, imm_ext, src_b, alu_result, result;
  logic [31:0] pc_plus4, pc_target, pc_next;
  logic        zero;

  riscv_sc_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .we  (regwrite),
    .ra1 (rs1),
    .ra2 (rs2),
    .wa  (rd),
    .wd  (result),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  assign imm_ext = ext_imm(instr, imm_src);
  assign src_b   = alu_src ? imm_ext : rd2;

  always_comb begin
    case (alu_ctl)
      ALU_ADD: alu_result = rd1 + src_b;
      ALU_SUB: alu_result = rd1 - src_b;
      ALU_AND: alu_result = rd1 & src_b;
      ALU_OR:  alu_result = rd1 | src_b;
      ALU_SLT: alu_result = {31'd0, ($signed(rd1) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  assign pc_plus4  = PC + 32'd4;
  assign pc_target = PC + imm_ext;
  assign pc_next   = (jump || (branch_eq && zero) || (branch_ne && !zero)) ? pc_target : pc_plus4;

  always_comb begin
    case (result_src)
      RES_MEM: result = read_data;
      RES_PC4: result = pc_plus4;
      default: result = alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) PC <= '0;
    else      PC <= pc_next;
  end

  assign addr       = alu_result[n-1:0];
  assign write_data = rd2[m-1:0];
  assign memwr      = mem_we;

endmodule

// File: tb/tb_riscv_sc_core.sv
// tb_riscv_sc_core: directed program run on riscv_sc_core with a 1K ROM and a
// 1K RAM modelled in the bench; outputs checked on the falling clock edge.
module tb_riscv_sc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  addr;
  logic [31:0] write_data;
  logic        memwr;
  logic [31:0] read_data;
  logic [31:0] PC;
  logic [31:0] instr;

  logic [31:0] rom [256];
  logic [31:0] ram [256];

  int n_vec = 0;
  int n_bad = 0;

  riscv_sc_core #(.n(10), .m(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .write_data (write_data),
    .memwr      (memwr),
    .read_data  (read_data),
    .PC         (PC),
    .instr      (instr)
  );

  always #5 clk = ~clk;

  assign instr     = rom[PC[9:2]];
  assign read_data = ram[addr[9:2]];

  always @(posedge clk) if (memwr) ram[addr[9:2]] <= write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [31:0] v, a, f, d;
    v = imm; a = rs1; f = f3; d = rd;
    return {v[11:0], a[4:0], f[2:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v, a, b;
    v = imm; a = rs1; b = rs2;
    return {v[11:5], b[4:0], a[4:0], 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] a, b, f, d;
    a = rs1; b = rs2; f = f3; d = rd;
    return {f7, b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, a, b, f;
    v = imm; a = rs1; b = rs2; f = f3;
    return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v, d;
    v = imm; d = rd;
    return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
  endfunction

  // Check the current cycle, then move to the next falling edge.
  task automatic step(input logic [31:0] pc, input logic mw, input logic [31:0] ad, input logic [31:0] wd);
    check($sformatf("pc@%0d", pc), PC, pc);
    check($sformatf("memwr@%0d", pc), {31'd0, memwr}, {31'd0, mw});
    if (mw) begin
      check($sformatf("addr@%0d", pc), {22'd0, addr}, ad);
      check($sformatf("wdata@%0d", pc), write_data, wd);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = 32'h0000_0013;
      ram[i] = 32'h0;
    end
    rom[0]  = enc_i(2, 0, 0, 1, 7'b0010011);         // 0:  addi x1,x0,2
    rom[1]  = enc_s(96, 1, 0);                       // 4:  sw x1,96(x0)
    rom[2]  = enc_i(4, 0, 0, 2, 7'b0010011);         // 8:  addi x2,x0,4
    rom[3]  = enc_s(92, 2, 0);                       // 12: sw x2,92(x0)
    rom[4]  = enc_i(92, 0, 2, 3, 7'b0000011);        // 16: lw x3,92(x0)
    rom[5]  = enc_r(7'b0000000, 3, 3, 0, 4);         // 20: add x4,x3,x3
    rom[6]  = enc_s(88, 4, 0);                       // 24: sw x4,88(x0)
    rom[7]  = enc_b(8, 0, 0, 0);                     // 28: beq x0,x0,+8
    rom[8]  = enc_s(80, 1, 0);                       // 32: sw x1,80(x0) (skipped)
    rom[9]  = enc_j(12, 5);                          // 36: jal x5,+12
    rom[10] = enc_s(84, 1, 0);                       // 40: skipped
    rom[11] = enc_s(84, 1, 0);                       // 44: skipped
    rom[12] = enc_s(100, 5, 0);                      // 48: sw x5,100(x0)
    rom[13] = enc_i(-3, 0, 0, 6, 7'b0010011);        // 52: addi x6,x0,-3
    rom[14] = enc_i(2, 0, 0, 7, 7'b0010011);         // 56: addi x7,x0,2
    rom[15] = enc_r(7'b0100000, 7, 6, 0, 8);         // 60: sub x8,x6,x7
    rom[16] = enc_s(104, 8, 0);                      // 64: sw x8,104(x0)
    rom[17] = enc_r(7'b0000000, 7, 6, 2, 9);         // 68: slt x9,x6,x7
    rom[18] = enc_s(108, 9, 0);                      // 72: sw x9,108(x0)
    rom[19] = enc_i(5, 0, 0, 0, 7'b0010011);         // 76: addi x0,x0,5
    rom[20] = enc_s(112, 0, 0);                      // 80: sw x0,112(x0)
    rom[21] = enc_r(7'b0000000, 7, 6, 6, 10);        // 84: or x10,x6,x7
    rom[22] = enc_s(116, 10, 0);                     // 88: sw x10,116(x0)
    rom[23] = enc_b(8, 7, 6, 0);                     // 92: beq x6,x7,+8 (not taken)
    rom[24] = enc_s(120, 7, 0);                      // 96: sw x7,120(x0)
    rom[25] = 32'hFFFF_FFFF;                         // 100: unsupported
    rom[26] = enc_b(8, 7, 6, 1);                     // 104: bne x6,x7,+8
    rom[27] = enc_s(124, 7, 0);                      // 108: sw x7,124(x0)
    rom[28] = enc_j(0, 0);                           // 112: jal x0,0

    @(negedge clk);
    #1;
    check("pc_in_reset", PC, 32'd0);
    rst = 1'b1;

    step(0, 0, 0, 0);
    step(4, 1, 96, 2);
    step(8, 0, 0, 0);
    step(12, 1, 92, 4);
    check("lw_addr", {22'd0, addr}, 32'd92);
    check("lw_data", read_data, 32'd4);
    step(16, 0, 0, 0);
    step(20, 0, 0, 0);
    step(24, 1, 88, 8);
    step(28, 0, 0, 0);
    step(36, 0, 0, 0);
    step(48, 1, 100, 40);
    step(52, 0, 0, 0);
    step(56, 0, 0, 0);
    step(60, 0, 0, 0);
    step(64, 1, 104, 32'hFFFF_FFFB);
    step(68, 0, 0, 0);
    step(72, 1, 108, 1);
    step(76, 0, 0, 0);
    step(80, 1, 112, 0);
    step(84, 0, 0, 0);
    step(88, 1, 116, 32'hFFFF_FFFF);
    step(92, 0, 0, 0);
    step(96, 1, 120, 2);
    step(100, 0, 0, 0);
    step(104, 0, 0, 0);
`ifndef RISCV_SC_BNE_EN
    step(108, 1, 124, 2);
`endif
    step(112, 0, 0, 0);
    step(112, 0, 0, 0);

    // Async reset mid-program: PC and GPRs clear without a clock edge.
    // instr at PC 0 has rs2 field = 2, so write_data exposes x2 (was 4).
    rst = 1'b0;
    #1;
    check("rst_pc", PC, 32'd0);
    check("rst_x2_clear", write_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    step(0, 0, 0, 0);
    check("run2_pc", PC, 32'd4);
    check("run2_memwr", {31'd0, memwr}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_sw_pc", PC, 32'd0);
    check("rst_mid_sw_memwr", {31'd0, memwr}, 32'd0);
    @(negedge clk);
    #1;

    check("ram_88", ram[22], 32'd8);
    check("ram_80_skipped", ram[20], 32'd0);
    check("ram_84_skipped", ram[21], 32'd0);
    check("ram_100_link", ram[25], 32'd40);
    check("ram_120", ram[30], 32'd2);
`ifdef RISCV_SC_BNE_EN
    check("ram_124_bne", ram[31], 32'd0);
`else
    check("ram_124_nobne", ram[31], 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
